// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants: word geometry, key-word type, round constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_pkg;

   localparam int REG_SIZE = 32;
   localparam int VEC_SIZE = 4;

   typedef logic [REG_SIZE-1:0] key_word_t;

   // Round constants indexed by the external round number. The table starts
   // at 02 because round index 0 here denotes the step producing round key 2.
   localparam logic [7:0] RCON [10] = '{
      8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
      8'h40, 8'h80, 8'h1b, 8'h36, 8'h6c
   };

   // Out-of-table round numbers contribute no round constant.
   function automatic logic [7:0] rcon_lookup(input logic [7:0] r);
      logic [7:0] rc;
      rc = 8'h00;
      if (r < 8'd10) begin
         rc = RCON[r[3:0]];
      end
      return rc;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte: sub_in -> sub_out.
// Latency: 0 cycles (pure combinational lookup).
// Backpressure: none.
// Ports: sub_in [7:0] byte to substitute, sub_out [7:0] substituted byte.
module aes_sbox (
   input  logic [7:0] sub_in,
   output logic [7:0] sub_out
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign sub_out = SBOX[sub_in];

endmodule

// File: rtl/key_expansion.sv
// AES-128 key expansion, one round step: next_key = expand(current_key, round).
// Latency: 1 cycle, valid_in -> valid_out; next_key holds between loads.
// Backpressure: none; accepts valid_in every cycle at full throughput.
// Ports: clk, rst (async, active-high), current_key[3:0] (word 0 = w0),
//        round (index in round[0][7:0]), valid_in, next_key[3:0], valid_out.
module key_expansion
   import aes_pkg::*;
#(
   parameter int regSize = 32,
   parameter int vecSize = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [vecSize-1:0][regSize-1:0]  current_key,
   input  logic [vecSize-1:0][regSize-1:0]  round,
   input  logic                             valid_in,
   output logic [vecSize-1:0][regSize-1:0]  next_key,
   output logic                             valid_out
);

   key_word_t  rot_w;
   key_word_t  sub_w;
   key_word_t  w0_n;
   key_word_t  w1_n;
   key_word_t  w2_n;
   key_word_t  w3_n;
   logic [7:0] rcon_b;

   // Only the low byte of round word 0 carries the round index.
   logic unused_round;
   assign unused_round = ^{round[vecSize-1:1], round[0][regSize-1:8]};

   // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}, b0 being the top byte.
   assign rot_w = {current_key[vecSize-1][23:0], current_key[vecSize-1][31:24]};

   // SubWord: one S-box per byte lane.
   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .sub_in  (rot_w[8*i +: 8]),
         .sub_out (sub_w[8*i +: 8])
      );
   end

   assign rcon_b = rcon_lookup(round[0][7:0]);

   // Chained XOR of the new words; round constant lands in the top byte only.
   assign w0_n = current_key[0] ^ sub_w ^ {rcon_b, 24'h0};
   assign w1_n = w0_n ^ current_key[1];
   assign w2_n = w1_n ^ current_key[2];
   assign w3_n = w2_n ^ current_key[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         next_key  <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            next_key[0] <= w0_n;
            next_key[1] <= w1_n;
            next_key[2] <= w2_n;
            next_key[3] <= w3_n;
         end
      end
   end

endmodule

// File: tb/tb_key_expansion.sv
// Directed self-checking bench for key_expansion.
// Latency: inputs driven on falling edge, outputs checked one falling edge later.
// Backpressure: none exercised; back-to-back loads are checked every cycle.
module tb_key_expansion;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [3:0][31:0]  current_key;
   logic [3:0][31:0]  round;
   logic              valid_in;
   logic [3:0][31:0]  next_key;
   logic              valid_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   localparam logic [127:0] KEY_ZERO = 128'h0;
   localparam logic [127:0] KEY_FIPS = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
   localparam logic [127:0] EXP_FIPS = 128'h296c7605_20a33939_8b542cb1_a3fafe17;

   always #5 clk = ~clk;

   key_expansion #(32, 4) dut (
      .clk         (clk),
      .rst         (rst),
      .current_key (current_key),
      .round       (round),
      .valid_in    (valid_in),
      .next_key    (next_key),
      .valid_out   (valid_out)
   );

   task automatic set_inputs(input logic [127:0] key, input logic [7:0] r, input logic vld);
      current_key = key;
      round       = {96'h0, 24'h0, r};
      valid_in    = vld;
   endtask

   task automatic test_reset();
      set_inputs(KEY_ZERO, 8'd0, 1'b0);
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if (next_key !== 128'h0) $display("FAIL reset_key: got %h expected %h", next_key, 128'h0);
      else pass_cnt++;
      total_cnt++;
      if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_out);
      else pass_cnt++;
      // Input presented while in reset must be discarded.
      @(negedge clk);
      set_inputs(KEY_FIPS, 8'd0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      total_cnt++;
      if (next_key !== 128'h0 || valid_out !== 1'b0)
         $display("FAIL reset_discard: got %h/%b expected %h/0", next_key, valid_out, 128'h0);
      else pass_cnt++;
      set_inputs(KEY_ZERO, 8'd0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_zero_key();
      @(negedge clk);
      set_inputs(KEY_ZERO, 8'd0, 1'b1);
      @(negedge clk);
      set_inputs(KEY_ZERO, 8'd0, 1'b0);
      total_cnt++;
      if (next_key !== {4{32'h61636363}})
         $display("FAIL zero_r0_key: got %h expected %h", next_key, {4{32'h61636363}});
      else pass_cnt++;
      total_cnt++;
      if (valid_out !== 1'b1) $display("FAIL zero_r0_valid: got %b expected 1", valid_out);
      else pass_cnt++;
   endtask

   task automatic test_fips_vector();
      @(negedge clk);
      set_inputs(KEY_FIPS, 8'd0, 1'b1);
      @(negedge clk);
      set_inputs(KEY_ZERO, 8'd0, 1'b0);
      total_cnt++;
      if (next_key !== EXP_FIPS) $display("FAIL fips_key: got %h expected %h", next_key, EXP_FIPS);
      else pass_cnt++;
      total_cnt++;
      if (valid_out !== 1'b1) $display("FAIL fips_valid: got %b expected 1", valid_out);
      else pass_cnt++;
   endtask

   task automatic test_rcon();
      logic [7:0]  rs   [4] = '{8'd7, 8'd9, 8'd12, 8'd255};
      logic [31:0] exps [4] = '{32'h78636363, 32'h0f636363, 32'h63636363, 32'h63636363};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_inputs(KEY_ZERO, rs[i], 1'b1);
         @(negedge clk);
         set_inputs(KEY_ZERO, 8'd0, 1'b0);
         total_cnt++;
         if (next_key !== {4{exps[i]}})
            $display("FAIL rcon_r%0d: got %h expected %h", rs[i], next_key, {4{exps[i]}});
         else pass_cnt++;
      end
   endtask

   task automatic test_round_ignored_bits();
      @(negedge clk);
      set_inputs(KEY_ZERO, 8'd0, 1'b1);
      round = {32'hdeadbeef, 32'hffffffff, 32'h12345678, 24'habcdef, 8'd7};
      @(negedge clk);
      set_inputs(KEY_ZERO, 8'd0, 1'b0);
      total_cnt++;
      if (next_key !== {4{32'h78636363}})
         $display("FAIL round_upper_ignored: got %h expected %h", next_key, {4{32'h78636363}});
      else pass_cnt++;
   endtask

   task automatic test_hold();
      @(negedge clk);
      set_inputs(KEY_FIPS, 8'd0, 1'b1);
      @(negedge clk);
      // Changing key with valid_in low must not disturb the held output.
      set_inputs(KEY_ZERO, 8'd9, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total_cnt++;
         if (next_key !== EXP_FIPS || valid_out !== 1'b0)
            $display("FAIL hold_cycle%0d: got %h/%b expected %h/0", i, next_key, valid_out, EXP_FIPS);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      set_inputs(KEY_ZERO, 8'd0, 1'b1);
      @(negedge clk);
      total_cnt++;
      if (next_key !== {4{32'h61636363}} || valid_out !== 1'b1)
         $display("FAIL b2b_first: got %h/%b expected %h/1", next_key, valid_out, {4{32'h61636363}});
      else pass_cnt++;
      set_inputs(KEY_FIPS, 8'd0, 1'b1);
      @(negedge clk);
      total_cnt++;
      if (next_key !== EXP_FIPS || valid_out !== 1'b1)
         $display("FAIL b2b_second: got %h/%b expected %h/1", next_key, valid_out, EXP_FIPS);
      else pass_cnt++;
      set_inputs(KEY_ZERO, 8'd7, 1'b1);
      @(negedge clk);
      set_inputs(KEY_ZERO, 8'd0, 1'b0);
      total_cnt++;
      if (next_key !== {4{32'h78636363}} || valid_out !== 1'b1)
         $display("FAIL b2b_third: got %h/%b expected %h/1", next_key, valid_out, {4{32'h78636363}});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (valid_out !== 1'b0) $display("FAIL b2b_valid_drop: got %b expected 0", valid_out);
      else pass_cnt++;
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      set_inputs(KEY_FIPS, 8'd0, 1'b1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      total_cnt++;
      if (next_key !== 128'h0 || valid_out !== 1'b0)
         $display("FAIL midrst_immediate: got %h/%b expected %h/0", next_key, valid_out, 128'h0);
      else pass_cnt++;
      // valid_in still high across the next edge while reset is held.
      @(posedge clk);
      #1;
      total_cnt++;
      if (next_key !== 128'h0 || valid_out !== 1'b0)
         $display("FAIL midrst_discard: got %h/%b expected %h/0", next_key, valid_out, 128'h0);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      set_inputs(KEY_ZERO, 8'd9, 1'b1);
      @(negedge clk);
      set_inputs(KEY_ZERO, 8'd0, 1'b0);
      total_cnt++;
      if (next_key !== {4{32'h0f636363}} || valid_out !== 1'b1)
         $display("FAIL midrst_reload: got %h/%b expected %h/1", next_key, valid_out, {4{32'h0f636363}});
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_zero_key();
      test_fips_vector();
      test_rcon();
      test_round_ignored_bits();
      test_hold();
      test_back_to_back();
      test_reset_midstream();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The module SHALL have parameter regSize, default 32, meaning the width of one key word in bits.
REQ-002 The module SHALL have parameter vecSize, default 4, meaning the number of words per key (AES-128).
REQ-003 The module SHALL take regSize and vecSize positionally, in that order; only 32/4 is supported.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port current_key, input, [vecSize-1:0][regSize-1:0]: round key in; word 0 = w0, bits [31:24] = first byte.
REQ-007 The module SHALL have port round, input, [vecSize-1:0][regSize-1:0]: round index in round[0][7:0]; the other bits and words are ignored.
REQ-008 The module SHALL have port valid_in, input, 1 bit: current_key/round are valid this cycle.
REQ-009 The module SHALL have port next_key, output, [vecSize-1:0][regSize-1:0]: next round key, registered.
REQ-010 The module SHALL have port valid_out, output, 1 bit: next_key was updated on the last edge.

Function
REQ-011 The module SHALL form rot = RotWord(current_key[3]), i.e. bytes {b1,b2,b3,b0} of {b0,b1,b2,b3}.
REQ-012 The module SHALL form sub = SubWord(rot), applying the FIPS-197 AES forward S-box to each of the 4 bytes.
REQ-013 The module SHALL take rcon from round[0][7:0] = r: r=0..9 -> 02,04,08,10,20,40,80,1B,36,6C (hex); r>=10 -> 00.
REQ-014 The module SHALL XOR rcon into bits [31:24] of sub only.
REQ-015 The module SHALL compute w0' = current_key[0] ^ sub ^ {rcon,24'h0}.
REQ-016 The module SHALL compute w1' = w0' ^ current_key[1], w2' = w1' ^ current_key[2] and w3' = w2' ^ current_key[3].
REQ-017 The module SHALL load {w3',w2',w1',w0'} into next_key[3:0] on the clk edge where valid_in=1, with 1-cycle latency.
REQ-018 The module SHALL set valid_out=1 in the cycle after each valid_in=1 and 0 otherwise.
REQ-019 The module SHALL hold next_key unchanged while valid_in=0.
REQ-020 The module SHALL accept back-to-back valid_in every cycle: full throughput, no stall or backpressure.
REQ-021 The module SHALL keep all arithmetic bitwise XOR with no carries and no width growth.

Reset
REQ-022 The module SHALL clear next_key to all zeros and valid_out to 0 immediately when rst asserts, independent of clk.
REQ-023 The module SHALL discard an input presented in the same cycle that rst is high.
REQ-024 The module SHALL capture the first input on the first rising clk edge after rst deasserts with valid_in=1.

Structure
REQ-025 The design SHALL place the REG_SIZE/VEC_SIZE constants, the key-word typedef and the 10-entry RCON constant table in a shared package, aes_pkg.
REQ-026 The design SHALL implement the S-box as one combinational sub-module, aes_sbox (8-bit in, 8-bit out, full 256-entry table), instantiated 4 times.
REQ-027 The module SHALL keep the datapath before the output register purely combinational.

Verification
REQ-028 The bench SHALL check: key all 0, r=0, valid_in=1 -> one cycle later all four next_key words = 61636363, valid_out=1.
REQ-029 The bench SHALL check: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, r=0 -> a3fafe17 8b542cb1 20a33939 296c7605.
REQ-030 The bench SHALL check: key all 0, r=7 -> all words 78636363; r=9 -> all words 0f636363.
REQ-031 The bench SHALL check: key all 0, r=12 -> all words 63636363 (rcon=00).
REQ-032 The bench SHALL check: valid_in=0 for 3 cycles after a load -> next_key holds and valid_out=0.
REQ-033 The bench SHALL check: rst pulsed between clk edges mid-stream -> next_key=0 and valid_out=0 immediately; the next load after release is correct.
